pe_cmd_sequencer: RTL

PE_CMD_SEQUENCER -- requirements
Module: pe_cmd_sequencer

---
 rtl/pe_cmd_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pe_cmd_sequencer.sv
// Issues the SET / LOAD_IFMAP / LOAD_WGHT / CONV / ACC command stream to a PE
// for one layer, pacing each opcode on the PE's ready handshake.
module pe_cmd_sequencer #(
  parameter int PASS_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [4:0]            i_layer_p,
  input  logic [2:0]            i_layer_q,
  input  logic [3:0]            i_layer_s,
  input  logic [PASS_WIDTH-1:0] i_num_pass,
  input  logic                  i_acc_en,
  input  logic                  i_reload_wght,
  input  logic                  i_abort,
  output logic [2:0]            o_opcode,
  output logic                  o_opcode_valid,
  input  logic                  i_opcode_ready,
  output logic [4:0]            o_layer_p,
  output logic [2:0]            o_layer_q,
  output logic [3:0]            o_layer_s,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic [PASS_WIDTH-1:0] o_pass_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_DONE} state_e;

  localparam logic [2:0] OP_SET  = 3'b000;
  localparam logic [2:0] OP_LI   = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_CONV = 3'b011;
  localparam logic [2:0] OP_ACC  = 3'b100;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  vld_q, vld_d;
  logic [4:0]            p_q, p_d;
  logic [2:0]            q_q, q_d;
  logic [3:0]            s_q, s_d;
  logic [PASS_WIDTH-1:0] num_q, num_d;
  logic                  acc_q, acc_d;
  logic                  rl_q, rl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abt_q, abt_d;
  logic [PASS_WIDTH-1:0] pc_q, pc_d;
  logic                  abort_pend_q, abort_pend_d;

  logic [PASS_WIDTH:0]   pass_nxt;
  logic                  last_pass;
  logic                  end_pass;
  logic [2:0]            nxt_op;

  // Extra bit keeps pc+1 from wrapping when pc sits at its maximum.
  assign pass_nxt  = {1'b0, pc_q} + {{PASS_WIDTH{1'b0}}, 1'b1};
  assign last_pass = (num_q == '0) || (pass_nxt >= {1'b0, num_q});

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    vld_d        = vld_q;
    p_d          = p_q;
    q_d          = q_q;
    s_d          = s_q;
    num_d        = num_q;
    acc_d        = acc_q;
    rl_d         = rl_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abt_d        = 1'b0;
    pc_d         = pc_q;
    abort_pend_d = abort_pend_q;
    end_pass     = 1'b0;
    nxt_op       = op_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        p_d          = i_layer_p;
        q_d          = i_layer_q;
        s_d          = i_layer_s;
        num_d        = i_num_pass;
        acc_d        = i_acc_en;
        rl_d         = i_reload_wght;
        pc_d         = '0;
        op_d         = OP_SET;
        vld_d        = 1'b1;
        busy_d       = 1'b1;
        abort_pend_d = 1'b0;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        // A handshake in the same cycle as abort still completes; the abort is
        // then honoured once the PE finishes that opcode.
        if (i_opcode_ready) begin
          vld_d        = 1'b0;
          abort_pend_d = i_abort;
          state_d      = S_GAP;
        end else if (i_abort) begin
          vld_d   = 1'b0;
          done_d  = 1'b1;
          abt_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        abort_pend_d = abort_pend_q | i_abort;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        abort_pend_d = abort_pend_q | i_abort;
        if (i_opcode_ready) begin
          case (op_q)
            OP_SET:  nxt_op = OP_LI;
            OP_LI:   nxt_op = ((pc_q == '0) || rl_q) ? OP_LW : OP_CONV;
            OP_LW:   nxt_op = OP_CONV;
            OP_CONV: if (acc_q) nxt_op = OP_ACC; else end_pass = 1'b1;
            default: end_pass = 1'b1;
          endcase
          if (abort_pend_q || i_abort) begin
            done_d  = 1'b1;
            abt_d   = 1'b1;
            state_d = S_DONE;
          end else if (end_pass && last_pass) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            vld_d   = 1'b1;
            state_d = S_ISSUE;
            if (end_pass) begin
              pc_d = pc_q + 1'b1;
              op_d = OP_LI;
            end else begin
              op_d = nxt_op;
            end
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_SET;
      vld_q        <= 1'b0;
      p_q          <= '0;
      q_q          <= '0;
      s_q          <= '0;
      num_q        <= '0;
      acc_q        <= 1'b0;
      rl_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abt_q        <= 1'b0;
      pc_q         <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      vld_q        <= vld_d;
      p_q          <= p_d;
      q_q          <= q_d;
      s_q          <= s_d;
      num_q        <= num_d;
      acc_q        <= acc_d;
      rl_q         <= rl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abt_q        <= abt_d;
      pc_q         <= pc_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign o_opcode       = op_q;
  assign o_opcode_valid = vld_q;
  assign o_layer_p      = p_q;
  assign o_layer_q      = q_q;
  assign o_layer_s      = s_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_aborted      = abt_q;
  assign o_pass_cnt     = pc_q;
endmodule
